ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the PS/2 interface. It sits directly downstream of the CPU write-strobe stage. When that stage delivers a single-cycle write pulse, this block latches the CPU data byte. It then runs the full PS/2 host-request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, and device acknowledge. It drives the open-drain PS/2 clock and data lines through output-enable pins and reports completion and error as single-cycle pulses.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// A single-cycle write strobe latches one byte. The block then runs the
// host-request sequence: clock inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit and device acknowledge. It drives the open-drain
// clock and data pins through active-high output enables. It reports the
// end of every transfer with a one-cycle done pulse, plus err on NACK or
// timeout.
//
// Handshake: the write port has no ready signal. A we pulse is accepted
// only while busy is low (state IDLE); a we seen while busy is high is
// dropped and does not disturb the transfer in flight. busy rises the
// cycle after an accepted we and falls in the cycle done pulses, so a new
// we is always accepted from the cycle after done.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] din,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One timer serves both the inhibit interval and the edge timeout, so it
  // is sized for the larger of the two.
  localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAX_COUNT + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RELEASE   = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          state;
  logic [8:0]      shift;     // {parity, data byte}, shifted out LSB first
  logic [3:0]      bit_cnt;   // device falling edges seen in SEND, 0..9
  logic [TW-1:0]   timer;
  logic            nack;      // device left data high on the ack edge

  // Synchroniser and edge-detect flops for the asynchronous pins
  logic            clk_s1;
  logic            clk_s2;
  logic            clk_prev;
  logic            data_s1;
  logic            data_s2;
  logic            fe;

  // Two-flop synchronisers plus a registered falling-edge flag. The flops
  // reset to 1 (idle bus level) so leaving reset never produces a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      fe       <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
      fe       <= clk_prev & ~clk_s2;
    end
  end

  // Transfer sequencer: all pin enables and status outputs are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      nack        <= 1'b0;
    end else begin
      // done and err are pulses; they are only raised for a single cycle
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (we) begin
            shift      <= {~^din, din};
            timer      <= '0;
            bit_cnt    <= '0;
            nack       <= 1'b0;
            ps2_clk_oe <= 1'b1;
            busy       <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          // Clock held low; the start bit goes out at the end of the interval
          if (timer == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_RELEASE: begin
          // Start bit stays asserted while the clock is handed to the device
          ps2_clk_oe <= 1'b0;
          timer      <= '0;
          bit_cnt    <= '0;
          state      <= S_SEND;
        end

        S_SEND: begin
          if (fe) begin
            timer <= '0;
            if (bit_cnt == 4'd9) begin
              // Tenth edge: release data so the device sees the stop bit
              ps2_data_oe <= 1'b0;
              state       <= S_ACK;
            end else begin
              // Edges 1..9 put out d0..d7 then parity; oe low means a 1 on the line
              ps2_data_oe <= ~shift[0];
              shift       <= {1'b0, shift[8:1]};
              bit_cnt     <= bit_cnt + 4'd1;
            end
          end else if (timer == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            busy        <= 1'b0;
            timer       <= '0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_ACK: begin
          if (fe) begin
            // The device pulls data low to acknowledge; high is a NACK
            nack  <= data_s2;
            timer <= '0;
            state <= S_WAIT_IDLE;
          end else if (timer == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            busy        <= 1'b0;
            timer       <= '0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        S_WAIT_IDLE: begin
          // The transfer ends only once the device has released both lines
          if (clk_s2 && data_s2) begin
            done  <= 1'b1;
            err   <= nack;
            busy  <= 1'b0;
            timer <= '0;
            state <= S_IDLE;
          end else if (fe) begin
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            busy        <= 1'b0;
            timer       <= '0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines,
// table-driven and random transfers checked against a frame model, plus
// hand-written timeout, busy-write and mid-transfer reset sequences.

module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TO   = 64;
  localparam int HALF = 20;   // device clock half period in system cycles

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  // Open-drain bus: a line is high only when nobody pulls it low
  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .din        (din),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame as the device sees it on the line:
  // bit 0 start (0), bits 1..8 data LSB first, bit 9 odd parity, bit 10 stop (1)
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_we(input logic [7:0] b);
    we  = 1'b1;
    din = b;
    @(negedge clk);
    we  = 1'b0;
    din = 8'($urandom);
  endtask

  // Behavioural device: waits for the request-to-send condition, then clocks
  // 11 edges, reading each bit at the end of the high phase, and acks or NACKs.
  task automatic device(input bit nack, output logic [10:0] frame, output bit ok);
    ok    = 1'b0;
    frame = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ps2_clk_i && !ps2_data_i) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) return;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      frame[k] = ps2_data_i;
      if (k == 10 && !nack) begin
        dev_data = 1'b0;
        repeat (3) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k < 10) repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  // One complete transfer with all timing and result checks
  task automatic run_xfer(input logic [7:0] b, input bit nack, input bit exp_err,
                          input bit extra_we, output logic [10:0] frame_out);
    int          cnt;
    bit          ok;
    logic [10:0] fr;
    logic [10:0] expf;
    exp_q.push_back(frame_of(b));
    start_we(b);
    check("busy_after_we", busy, 1);
    cnt = 0;
    while (ps2_clk_oe && !ps2_data_oe && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("start_before_release", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    check("clk_released", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    if (extra_we) begin
      we  = 1'b1;
      din = 8'h55;
      @(negedge clk);
      we  = 1'b0;
    end
    device(nack, fr, ok);
    check("device_start_seen", ok, 1);
    expf = exp_q.pop_front();
    check("frame", fr, expf);
    frame_out = fr;
    cnt = 0;
    while (!done && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    check("err_at_done", err, exp_err);
    check("busy_at_done", busy, 0);
    check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    check("done_single_pulse", {done, err}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] din;
    bit         nack;
    bit         exp_err;
    bit         exp_par;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [10:0] fr;
    int          cnt;
    bit          nk;
    logic [7:0]  b;

    tbl[0] = '{8'hF4, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h7E, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b0);

    // Table-driven transfers
    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].din, tbl[i].nack, tbl[i].exp_err, 1'b0, fr);
      check("parity_bit", fr[9], tbl[i].exp_par);
    end

    // Randomised transfers against the frame model
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom_range(0, 255));
      nk = ($urandom_range(0, 3) == 0);
      run_xfer(b, nk, nk, 1'b0, fr);
    end

    // A second write while busy must be ignored
    run_xfer(8'hC3, 1'b0, 1'b0, 1'b1, fr);

    // Device never clocks: timeout after TO cycles from clock release
    start_we(8'h3C);
    cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    cnt = 0;
    while (!done && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_cycles", cnt, TO);
    check("timeout_err", err, 1);
    check("timeout_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    @(negedge clk);
    check("timeout_pulse_end", {done, err, busy}, 3'b000);

    // Reset in the middle of SEND
    start_we(8'h3C);
    cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_send_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_reset_release", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b0);
    @(negedge clk);
    reset    = 1'b1;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b0);
    run_xfer(8'hAA, 1'b0, 1'b0, 1'b0, fr);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time limit for the whole run
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
